// File: rtl/simf_issue_arbiter.sv
// Round-robin issue arbiter for the SIMF ALU: picks one ready, not-in-flight
// wavefront per decision cycle and tracks in-flight state until retire.
module simf_issue_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_WF-1:0]   wf_ready,
    input  logic                issue_alu_ready,
    input  logic                vgpr_instr_done,
    input  logic [WFID_W-1:0]   vgpr_instr_done_wfid,
    output logic                issue_alu_select,
    output logic [WFID_W-1:0]   issue_wfid,
    output logic [NUM_WF-1:0]   wf_pending,
    output logic [WFID_W:0]     inflight_cnt,
    output logic                err_spurious_done
);

    typedef enum logic {ARB, HOLD} state_t;

    state_t              state_reg;
    logic [WFID_W-1:0]   ptr_reg;
    logic [WFID_W-1:0]   ptr_next;
    logic [NUM_WF-1:0]   pending_reg;
    logic [NUM_WF-1:0]   pending_next;
    logic [WFID_W:0]     cnt_reg;
    logic [WFID_W:0]     cnt_next;
    logic                sel_reg;
    logic [WFID_W-1:0]   wfid_reg;
    logic                err_reg;

    logic [NUM_WF-1:0]   eligible;
    logic [NUM_WF-1:0]   above_ptr;
    logic [NUM_WF-1:0]   retire_vec;
    logic [NUM_WF-1:0]   grant_vec;
    logic [WFID_W-1:0]   g_high;
    logic [WFID_W-1:0]   g_low;
    logic [WFID_W-1:0]   g;
    logic                found_high;
    logic                found_low;
    logic                grant;
    logic                retire_valid;

    assign eligible = wf_ready & ~pending_reg;

    // Per-slot decode; an out-of-range retire id matches no slot, so it
    // falls through to the spurious path.
    generate
        for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_slot
            assign above_ptr[gi]  = (WFID_W'(gi) >= ptr_reg);
            assign retire_vec[gi] = vgpr_instr_done && pending_reg[gi] &&
                                    (vgpr_instr_done_wfid == WFID_W'(gi));
            assign grant_vec[gi]  = grant && (g == WFID_W'(gi));
        end
    endgenerate

    // Two priority searches: lowest eligible at/above ptr, and lowest overall
    // as the wrap-around fallback.
    always_comb begin
        g_high     = '0;
        g_low      = '0;
        found_high = 1'b0;
        found_low  = 1'b0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (eligible[i] && above_ptr[i]) begin
                g_high     = WFID_W'(i);
                found_high = 1'b1;
            end
            if (eligible[i]) begin
                g_low     = WFID_W'(i);
                found_low = 1'b1;
            end
        end
        g     = found_high ? g_high : g_low;
        grant = (state_reg == ARB) && issue_alu_ready && found_low;
    end

    always_comb begin
        retire_valid = |retire_vec;
        pending_next = (pending_reg | grant_vec) & ~retire_vec;
        ptr_next     = (g == WFID_W'(NUM_WF - 1)) ? '0 : g + 1'b1;
        cnt_next     = cnt_reg;
        case ({grant, retire_valid})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ARB;
            ptr_reg     <= '0;
            pending_reg <= '0;
            cnt_reg     <= '0;
            sel_reg     <= 1'b0;
            wfid_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            sel_reg     <= grant;
            err_reg     <= err_reg | (vgpr_instr_done & ~retire_valid);
            if (grant) begin
                state_reg <= HOLD;
                ptr_reg   <= ptr_next;
                wfid_reg  <= g;
            end else begin
                state_reg <= ARB;
            end
        end
    end

    assign issue_alu_select  = sel_reg;
    assign issue_wfid        = wfid_reg;
    assign wf_pending        = pending_reg;
    assign inflight_cnt      = cnt_reg;
    assign err_spurious_done = err_reg;

endmodule

// File: tb/tb_simf_issue_arbiter.sv
// Directed bench for simf_issue_arbiter: expected issue ids are queued as
// stimulus is applied and popped whenever the DUT strobes.
module tb_simf_issue_arbiter;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_WF-1:0]   wf_ready;
    logic                issue_alu_ready;
    logic                vgpr_instr_done;
    logic [WFID_W-1:0]   vgpr_instr_done_wfid;
    logic                issue_alu_select;
    logic [WFID_W-1:0]   issue_wfid;
    logic [NUM_WF-1:0]   wf_pending;
    logic [WFID_W:0]     inflight_cnt;
    logic                err_spurious_done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int rr_ids[3] = '{3, 7, 39};

    simf_issue_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wf_ready             (wf_ready),
        .issue_alu_ready      (issue_alu_ready),
        .vgpr_instr_done      (vgpr_instr_done),
        .vgpr_instr_done_wfid (vgpr_instr_done_wfid),
        .issue_alu_select     (issue_alu_select),
        .issue_wfid           (issue_wfid),
        .wf_pending           (wf_pending),
        .inflight_cnt         (inflight_cnt),
        .err_spurious_done    (err_spurious_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample #1 after the edge; every strobe is matched
    // against the scoreboard, and strobes with nothing queued are flagged.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 64'(issue_alu_select), 64'd0);
        end else if (issue_alu_select) begin
            e = exp_q.pop_front();
            chk("strobe_wfid", 64'(issue_wfid), 64'(e));
            $display("issue wfid=%0d t=%0t", issue_wfid, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},  64'(issue_alu_select), 64'd0);
        chk({tag, "_wfid"}, 64'(issue_wfid), 64'd0);
        chk({tag, "_pend"}, 64'(wf_pending), 64'd0);
        chk({tag, "_cnt"},  64'(inflight_cnt), 64'd0);
        chk({tag, "_err"},  64'(err_spurious_done), 64'd0);
    endtask

    initial begin
        rst                  = 1'b1;
        wf_ready             = '1;
        issue_alu_ready      = 1'b1;
        vgpr_instr_done      = 1'b0;
        vgpr_instr_done_wfid = '0;

        // Reset held two cycles with everything ready
        tick(); chk_reset_vals("rst_a");
        tick(); chk_reset_vals("rst_b");
        rst = 1'b0;
        exp_q.push_back(0);
        tick();
        chk("first_sel", 64'(issue_alu_select), 64'd1);
        chk("first_pend", 64'(wf_pending), 64'd1);
        chk("first_cnt", 64'(inflight_cnt), 64'd1);
        rst = 1'b1;
        wf_ready = '0;
        tick(); chk_reset_vals("rst_mid");
        rst = 1'b0;
        tick();

        // Round robin over {3,7,39} with immediate retire, wrapping to 3
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) exp_q.push_back(rr_ids[k]);
        wf_ready = (40'd1 << 3) | (40'd1 << 7) | (40'd1 << 39);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_sel", 64'(issue_alu_select), 64'd1);
            chk("rr_cnt", 64'(inflight_cnt), 64'd1);
            if (k % 3 == 2) chk("rr_ptr_wrap", 64'(dut.ptr_reg), 64'd0);
            vgpr_instr_done      = 1'b1;
            vgpr_instr_done_wfid = WFID_W'(rr_ids[k % 3]);
            tick();
            vgpr_instr_done = 1'b0;
            chk("rr_gap", 64'(issue_alu_select), 64'd0);
            chk("rr_cnt_ret", 64'(inflight_cnt), 64'd0);
        end
        wf_ready = '0;
        tick();

        // Pending wavefront is not reissued until retired
        wf_ready = 40'd1 << 5;
        exp_q.push_back(5);
        tick();
        chk("pb_sel", 64'(issue_alu_select), 64'd1);
        chk("pb_pend5", 64'(wf_pending[5]), 64'd1);
        chk("pb_cnt", 64'(inflight_cnt), 64'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("pb_nostrobe", 64'(issue_alu_select), 64'd0);
        end
        vgpr_instr_done      = 1'b1;
        vgpr_instr_done_wfid = 6'd5;
        exp_q.push_back(5);
        tick();
        vgpr_instr_done = 1'b0;
        chk("pb_m1_sel", 64'(issue_alu_select), 64'd0);
        chk("pb_m1_pend5", 64'(wf_pending[5]), 64'd0);
        chk("pb_m1_cnt", 64'(inflight_cnt), 64'd0);
        tick();
        chk("pb_m2_sel", 64'(issue_alu_select), 64'd1);
        wf_ready             = '0;
        vgpr_instr_done      = 1'b1;
        vgpr_instr_done_wfid = 6'd5;
        tick();
        vgpr_instr_done = 1'b0;
        chk("pb_clean_cnt", 64'(inflight_cnt), 64'd0);

        // ALU backpressure
        issue_alu_ready = 1'b0;
        wf_ready        = 40'd1 << 2;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_nostrobe", 64'(issue_alu_select), 64'd0);
        end
        issue_alu_ready = 1'b1;
        exp_q.push_back(2);
        tick();
        chk("bp_sel", 64'(issue_alu_select), 64'd1);
        wf_ready             = '0;
        vgpr_instr_done      = 1'b1;
        vgpr_instr_done_wfid = 6'd2;
        tick();
        vgpr_instr_done = 1'b0;
        chk("bp_clean_cnt", 64'(inflight_cnt), 64'd0);

        // Spurious retires: not pending, then out of range
        chk("sp_err_pre", 64'(err_spurious_done), 64'd0);
        vgpr_instr_done      = 1'b1;
        vgpr_instr_done_wfid = 6'd12;
        tick();
        chk("sp_err12", 64'(err_spurious_done), 64'd1);
        chk("sp_pend12", 64'(wf_pending), 64'd0);
        chk("sp_cnt12", 64'(inflight_cnt), 64'd0);
        vgpr_instr_done_wfid = 6'd45;
        tick();
        chk("sp_err45", 64'(err_spurious_done), 64'd1);
        chk("sp_pend45", 64'(wf_pending), 64'd0);
        chk("sp_cnt45", 64'(inflight_cnt), 64'd0);
        vgpr_instr_done = 1'b0;
        tick();
        chk("sp_sticky", 64'(err_spurious_done), 64'd1);

        // Grant of 9 and retire of 4 on the same edge, then reset mid-flight
        wf_ready = 40'd1 << 4;
        exp_q.push_back(4);
        tick();
        chk("cc_sel4", 64'(issue_alu_select), 64'd1);
        wf_ready = 40'd1 << 9;
        tick();
        chk("cc_hold", 64'(issue_alu_select), 64'd0);
        vgpr_instr_done      = 1'b1;
        vgpr_instr_done_wfid = 6'd4;
        exp_q.push_back(9);
        tick();
        vgpr_instr_done = 1'b0;
        chk("cc_sel9", 64'(issue_alu_select), 64'd1);
        chk("cc_pend9", 64'(wf_pending[9]), 64'd1);
        chk("cc_pend4", 64'(wf_pending[4]), 64'd0);
        chk("cc_cnt", 64'(inflight_cnt), 64'd1);
        rst = 1'b1;
        tick(); chk_reset_vals("cc_rst");
        rst      = 1'b0;
        wf_ready = '0;
        tick();
        vgpr_instr_done      = 1'b1;
        vgpr_instr_done_wfid = 6'd9;
        tick();
        vgpr_instr_done = 1'b0;
        chk("cc_stale_err", 64'(err_spurious_done), 64'd1);
        chk("cc_stale_cnt", 64'(inflight_cnt), 64'd0);
        chk("cc_stale_pend", 64'(wf_pending), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
